// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with a scan-code FIFO.
//   Synchronises and filters the raw PS/2 clock and data lines, deframes 11-bit frames
//   (start, 8 data LSB first, odd parity, stop) and queues the bytes in a FIFO.
//   The block only receives and never drives the PS/2 lines.
// Optional feature: define PS2_PARITY_CHECK_EN to drop bad-parity frames and flag them on rx_error.
//   When it is undefined, the parity bit is captured but ignored.
// Ports:
//   clk            system clock, 14 MHz or faster
//   reset          synchronous, active-high reset
//   ps2_clk_i      raw PS/2 clock (asynchronous)
//   ps2_data_i     raw PS/2 data (asynchronous)
//   rx_read        pop request, single-cycle pulse
//   rx_scan_code   last popped byte, held until the next pop
//   rx_data_ready  FIFO not empty
//   rx_error       1-cycle pulse on a stop/parity/timeout error
//   rx_overflow    sticky, set when a byte is dropped because the FIFO is full
module ps2_rx_fifo #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 14000,
  parameter int unsigned FIFO_AW     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       rx_read,
  output logic [7:0] rx_scan_code,
  output logic       rx_data_ready,
  output logic       rx_error,
  output logic       rx_overflow
);

  localparam int unsigned FltW  = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned PtrW  = FIFO_AW + 1;
  localparam int unsigned Depth = 1 << FIFO_AW;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [1:0]      clk_sync_q, dat_sync_q;
  logic            clk_s, dat_s;
  logic            filt_q, filt_d;
  logic [FltW-1:0] flt_cnt_q, flt_cnt_d;
  logic            fall;

  state_e          state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d, par_ok;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            push_q, push_d;
  logic [7:0]      push_byte_q, push_byte_d;
  logic            err_q, err_d;

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [7:0]      scan_q;
  logic            ovf_q;
  logic            empty, full, pop_en, push_en;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // The filtered clock only follows the synced level once it has differed for FILTER_LEN
  // consecutive samples; a falling edge is reported in the cycle that change is accepted.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    fall      = 1'b0;
    if (clk_s != filt_q) begin
      if (flt_cnt_q == FltW'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
        fall   = filt_q;
      end else begin
        flt_cnt_d = flt_cnt_q + FltW'(1);
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  // Next-state logic: the FSM only moves on filtered falling edges or on a timeout.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tmo_d       = tmo_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    err_d       = 1'b0;
    if (fall) begin
      tmo_d = '0;
      unique case (state_q)
        StIdle: begin
          if (!dat_s) begin
            state_d  = StData;
            bitcnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d  = {dat_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_d   = dat_s;
          state_d = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (dat_s && par_ok) begin
            push_d      = 1'b1;
            push_byte_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
        state_d = StIdle;
        tmo_d   = '0;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                   (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign pop_en  = rx_read && !empty;
  // A pop on a full FIFO frees the head slot in the same edge, so the push may land there.
  assign push_en = push_q && (!full || pop_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_q      <= 1'b1;
      flt_cnt_q   <= '0;
      state_q     <= StIdle;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      push_q      <= 1'b0;
      push_byte_q <= 8'h00;
      err_q       <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      scan_q      <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q  <= {dat_sync_q[0], ps2_data_i};
      filt_q      <= filt_d;
      flt_cnt_q   <= flt_cnt_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
      err_q       <= err_d;
      if (push_en) wptr_q <= wptr_q + PtrW'(1);
      if (pop_en) begin
        rptr_q <= rptr_q + PtrW'(1);
        scan_q <= mem_q[rptr_q[FIFO_AW-1:0]];
      end
      if (push_q && full && !pop_en) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push_en) mem_q[wptr_q[FIFO_AW-1:0]] <= push_byte_q;
  end

  always_comb begin
    rx_scan_code  = scan_q;
    rx_data_ready = !empty;
    rx_error      = err_q;
    rx_overflow   = ovf_q;
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;

  localparam int FLT = 8;
  localparam int TMO = 600;
  localparam int H   = 40;  // half PS/2 bit period in system clocks

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_read = 1'b0;
  logic [7:0] rx_scan_code;
  logic       rx_data_ready, rx_error, rx_overflow;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FILTER_LEN (FLT),
    .TIMEOUT_CYC(TMO),
    .FIFO_AW    (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .rx_read      (rx_read),
    .rx_scan_code (rx_scan_code),
    .rx_data_ready(rx_data_ready),
    .rx_error     (rx_error),
    .rx_overflow  (rx_overflow)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: byte queue, last popped byte, sticky overflow.
  logic [7:0] q[$];
  logic [7:0] m_last = 8'h00;
  bit         m_ovf = 1'b0;
  bit         settle = 1'b1;  // outputs may legitimately be in transit
  int         err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!settle) begin
      check("ready", rx_data_ready, q.size() != 0);
      check("scan_code", rx_scan_code, m_last);
      check("overflow", rx_overflow, m_ovf);
      check("error_quiet", rx_error, 1'b0);
    end else if (rx_error === 1'b1) begin
      err_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  // Drives the first n bits of an 11-bit frame; optionally glitches ps2_clk low after bit 3.
  task automatic drive_bits(input logic [10:0] f, input int n, input bit glitch, input bit mark);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      cyc(H);
      if (mark && i == 10) begin
        err_seen = 0;
        settle   = 1'b1;
      end
      ps2_clk = 1'b0;
      cyc(H);
      ps2_clk = 1'b1;
      if (glitch && i == 3) begin
        cyc(H / 2);
        ps2_clk = 1'b0;
        cyc(FLT - 2);
        ps2_clk = 1'b1;
        cyc(H / 2);
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input bit glitch);
    bit bad;
    drive_bits({stop, par, b, 1'b0}, 11, glitch, 1'b1);
    ps2_data = 1'b1;
    cyc(H);
    bad = !stop;
`ifdef PS2_PARITY_CHECK_EN
    if (^{b, par} == 1'b0) bad = 1'b1;
`endif
    check("frame_error_count", err_seen, bad ? 1 : 0);
    if (!bad) begin
      if (q.size() == 8) m_ovf = 1'b1;
      else q.push_back(b);
    end
    settle = 1'b0;
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, odd_par(b), 1'b1, 1'b0);
  endtask

  task automatic pop();
    rx_read = 1'b1;
    cyc(1);
    rx_read = 1'b0;
    if (q.size() > 0) m_last = q.pop_front();
  endtask

  task automatic do_reset();
    settle = 1'b1;
    reset  = 1'b1;
    cyc(3);
    reset  = 1'b0;
    q.delete();
    m_last = 8'h00;
    m_ovf  = 1'b0;
    cyc(1);
    settle = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    cyc(2);
    do_reset();
    check("rst_scan", rx_scan_code, 8'h00);
    check("rst_ready", rx_data_ready, 1'b0);
    check("rst_err", rx_error, 1'b0);
    check("rst_ovf", rx_overflow, 1'b0);

    // Single byte, then a pop, then a pop on an empty FIFO.
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("t1_ready", rx_data_ready, 1'b1);
    pop();
    check("t1_scan", rx_scan_code, 8'h1C);
    check("t1_ready_after", rx_data_ready, 1'b0);
    pop();
    check("t1_empty_pop", rx_scan_code, 8'h1C);

    // Two bytes queued, popped in order.
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    good(8'h1C);
    check("t2_ready", rx_data_ready, 1'b1);
    pop();
    check("t2_first", rx_scan_code, 8'hF0);
    check("t2_ready_mid", rx_data_ready, 1'b1);
    pop();
    check("t2_second", rx_scan_code, 8'h1C);
    check("t2_ready_end", rx_data_ready, 1'b0);

    // 0x12 has even weight, so parity bit 0 makes the 9-bit total even.
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("t4_ready", rx_data_ready, 1'b0);
`else
    check("t4_ready", rx_data_ready, 1'b1);
    pop();
    check("t4_scan", rx_scan_code, 8'h12);
`endif

    // Clocks stop after the start bit and 4 data bits.
    drive_bits({1'b1, 1'b1, 8'hA7, 1'b0}, 5, 1'b0, 1'b0);
    err_seen = 0;
    settle   = 1'b1;
    ps2_data = 1'b1;
    cyc(TMO + 50);
    check("t5_timeout_errors", err_seen, 1);
    settle = 1'b0;
    good(8'h5A);
    pop();
    check("t5_scan", rx_scan_code, 8'h5A);

    // Short low glitch on ps2_clk must not be taken as a bit.
    send_frame(8'h3C, odd_par(8'h3C), 1'b1, 1'b1);
    pop();
    check("t6_glitch_scan", rx_scan_code, 8'h3C);

    // Randomized frames, some corrupted or glitched, with random pops in between.
    for (int i = 0; i < 30; i++) begin
      int kind;
      b    = 8'($urandom);
      kind = $urandom_range(0, 7);
      if (kind == 0) send_frame(b, odd_par(b), 1'b0, 1'b0);
      else if (kind == 1) send_frame(b, ~odd_par(b), 1'b1, 1'b0);
      else send_frame(b, odd_par(b), 1'b1, kind == 2);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        pop();
        cyc($urandom_range(0, 5));
      end
    end

    // Fill past capacity.
    while (q.size() > 0) pop();
    for (int i = 1; i <= 9; i++) good(8'(i));
    check("t3_ovf", rx_overflow, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      pop();
      check("t3_order", rx_scan_code, 8'(i));
    end
    check("t3_ready_end", rx_data_ready, 1'b0);
    check("t3_ovf_sticky", rx_overflow, 1'b1);

    // Reset in the middle of a frame with a byte queued.
    good(8'h33);
    drive_bits({1'b1, odd_par(8'h77), 8'h77, 1'b0}, 4, 1'b0, 1'b0);
    do_reset();
    check("t6_rst_scan", rx_scan_code, 8'h00);
    check("t6_rst_ready", rx_data_ready, 1'b0);
    check("t6_rst_ovf", rx_overflow, 1'b0);
    good(8'h29);
    pop();
    check("t6_after_reset", rx_scan_code, 8'h29);

    cyc(5);
    settle = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
